// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word size and the NOP used to pad the unused tail of the program.
package mips_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
endpackage

// File: rtl/loader_word_counter.sv
// Word index register for the loader: clear, increment, terminal count,
// and the byte address of the current word.
module loader_word_counter
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic        o_tc,
  output logic [31:0] o_addr
);
  localparam int IW = $clog2(DEPTH_WORDS);

  logic [IW-1:0] r_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_inc) r_idx <= r_idx + IW'(1);
  end

  assign o_tc   = (r_idx == IW'(DEPTH_WORDS - 1));
  // 32-bit arithmetic; wraps silently past the top of the address space
  assign o_addr = BASE_ADDR + (32'(r_idx) * 32'(WORD_BYTES));
endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, pads the tail with NOPs and
// then releases the datapath via cpu_run.
module imem_loader
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_write_enabled,
  output logic [31:0] mem_input_address,
  output logic [31:0] mem_input_data,
  output logic        cpu_run,
  output logic        busy,
  output logic        err_overflow,
  output logic [$clog2(DEPTH_WORDS+1)-1:0] words_loaded
);
  localparam int WL = $clog2(DEPTH_WORDS + 1);

  loader_state_t r_state;
  logic          r_cpu_run;
  logic          r_busy;
  logic          r_err;
  logic [WL-1:0] r_words;

  logic w_tc, w_clr, w_inc, w_accept, w_start_ok;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERROR);
  assign w_accept   = (r_state == ST_LOAD) && word_valid;
  assign w_clr      = w_start_ok;
  // idx parks on the last word rather than wrapping when the load ends
  assign w_inc      = !w_tc && (w_accept || r_state == ST_FILL);

  loader_word_counter #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_tc   (w_tc),
    .o_addr (mem_input_address)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cpu_run <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (word_valid) begin
            r_words <= r_words + WL'(1);
            if (word_last && !w_tc) begin
              r_state <= ST_FILL;
            end else if (word_last) begin
              r_state   <= ST_RUN;
              r_cpu_run <= 1'b1;
              r_busy    <= 1'b0;
            end else if (w_tc) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_FILL: begin
          if (w_tc) begin
            r_state   <= ST_RUN;
            r_cpu_run <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          if (w_start_ok) begin
            r_state   <= ST_LOAD;
            r_cpu_run <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_words   <= '0;
          end
        end
      endcase
    end
  end

  assign word_ready        = (r_state == ST_LOAD);
  assign mem_write_enabled = w_accept || (r_state == ST_FILL);
  assign mem_input_data    = w_accept ? word_data : NOP_INSTR;
  assign cpu_run           = r_cpu_run;
  assign busy              = r_busy;
  assign err_overflow      = r_err;
  assign words_loaded      = r_words;
endmodule
